// File: rtl/keycode_player.sv
// keycode_player: queues key events and replays each keycode for a number of
// frames, paced by a frame strobe sampled in the Clk domain.
// Optional build macro KEYCODE_GAP_EN: when defined, one frame of 8'h00 is
// inserted after every event; when undefined, events play back-to-back.
module keycode_player #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_clk,
  input  logic                    ev_valid,
  input  logic [7:0]              ev_code,
  input  logic [HOLD_W-1:0]       ev_hold,
  output logic                    ev_ready,
  input  logic                    flush,
  output logic [7:0]              keycode,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0]        code;
    logic [HOLD_W-1:0] hold;
  } ev_t;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t            state, state_nx;
  logic [7:0]        key_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;

  logic fc_s1, fc_s2, fc_d;
  logic frame_tick;

  ev_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  ev_t           head;
  logic [HOLD_W-1:0] head_hold;

  // two-flop synchronizer on the frame strobe plus a delay flop for edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_s1 <= 1'b0;
      fc_s2 <= 1'b0;
      fc_d  <= 1'b0;
    end else begin
      fc_s1 <= frame_clk;
      fc_s2 <= fc_s1;
      fc_d  <= fc_s2;
    end
  end

  assign frame_tick = fc_s2 & ~fc_d;

  // occupancy flags come from the registered count, so a same-cycle push
  // into an empty FIFO is never visible to the pop decision
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign ev_ready   = ~full;
  assign push       = ev_valid & ev_ready & ~flush;
  assign fifo_count = count;
  assign busy       = (state != IDLE);
  assign head       = mem[rd_ptr];
  assign head_hold  = (head.hold == '0) ? HOLD_W'(1) : head.hold;

  // event storage; contents need no reset because count gates every read
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= '{code: ev_code, hold: ev_hold};
  end

  // FIFO pointers and occupancy; flush empties the queue outright
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state, keycode and hold counter registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      keycode  <= 8'h00;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      keycode  <= key_nx;
      hold_cnt <= hold_nx;
    end
  end

  // next-state logic; keycode only moves on a frame tick or a flush
  always_comb begin
    state_nx = state;
    key_nx   = keycode;
    hold_nx  = hold_cnt;
    pop      = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      key_nx   = 8'h00;
      hold_nx  = '0;
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            key_nx   = head.code;
            hold_nx  = head_hold;
            state_nx = HOLD;
          end else begin
            key_nx   = 8'h00;
          end
        end
        HOLD: begin
          if (hold_cnt > HOLD_W'(1)) begin
            hold_nx = hold_cnt - HOLD_W'(1);
          end else begin
`ifdef KEYCODE_GAP_EN
            state_nx = GAP;
            key_nx   = 8'h00;
            hold_nx  = '0;
`else
            if (!empty) begin
              pop      = 1'b1;
              key_nx   = head.code;
              hold_nx  = head_hold;
            end else begin
              state_nx = IDLE;
              key_nx   = 8'h00;
              hold_nx  = '0;
            end
`endif
          end
        end
        GAP: begin
          if (!empty) begin
            pop      = 1'b1;
            key_nx   = head.code;
            hold_nx  = head_hold;
            state_nx = HOLD;
          end else begin
            state_nx = IDLE;
            key_nx   = 8'h00;
          end
        end
        default: begin
          state_nx = IDLE;
          key_nx   = 8'h00;
          hold_nx  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_player.sv
// Scoreboard bench for keycode_player: expected keycodes per frame are queued
// when events are pushed and popped/compared after each frame tick.
module tb_keycode_player;

`ifdef KEYCODE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic       ev_valid = 1'b0, flush = 1'b0;
  logic [7:0] ev_code = 8'h00, ev_hold = 8'h00;
  logic       ev_ready, busy;
  logic [7:0] keycode;
  logic [2:0] fifo_count;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q [$];

  keycode_player #(.DEPTH(4), .HOLD_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_hold(ev_hold),
    .ev_ready(ev_ready), .flush(flush), .keycode(keycode),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(k);
  endtask

  task automatic push_ev(input logic [7:0] c, input logic [7:0] h);
    @(negedge Clk);
    ev_valid = 1'b1; ev_code = c; ev_hold = h;
    @(posedge Clk);
    #1 ev_valid = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    chk(tag, keycode, e);
  endtask

  // one frame strobe, then compare keycode with the scoreboard head
  task automatic frame(input string tag);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    sb_check(tag);
  endtask

  // frame strobe with a push landing on the very edge that sees frame_tick
  task automatic frame_push(input string tag, input logic [7:0] c, input logic [7:0] h);
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    ev_valid = 1'b1; ev_code = c; ev_hold = h;
    @(posedge Clk);
    #1 ev_valid = 1'b0;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    sb_check(tag);
  endtask

  task automatic do_flush();
    @(negedge Clk) flush = 1'b1;
    @(posedge Clk);
    #1 flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, while asserted and after release
    #23;
    chk("rst_key", keycode, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", fifo_count, 3'd0);
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_ready", ev_ready, 1'b1);
    chk("rst_key2", keycode, 8'h00);

    // single event hold 3
    push_ev(8'h1A, 8'd3);
    chk("one_cnt", fifo_count, 3'd1);
    sb(8'h1A, 3); sb(8'h00, 2);
    frame("one_t1"); frame("one_t2"); frame("one_t3");
    chk("one_busy3", busy, 1'b1);
    frame("one_t4");
    chk("one_busy4", busy, GAP_EN);
    frame("one_t5");
    chk("one_busy5", busy, 1'b0);

    // two events: back-to-back or with a gap frame
    push_ev(8'h04, 8'd2);
    push_ev(8'h07, 8'd1);
    sb(8'h04, 2);
    if (GAP_EN) sb(8'h00, 1);
    sb(8'h07, 1); sb(8'h00, 2);
    for (int i = 0; i < (GAP_EN ? 6 : 5); i++) frame("two_seq");
    chk("two_busy", busy, 1'b0);

    // zero hold plays one frame
    push_ev(8'h16, 8'd0);
    sb(8'h16, 1); sb(8'h00, 2);
    frame("h0_t1"); frame("h0_t2"); frame("h0_t3");
    chk("h0_busy", busy, 1'b0);

    // push on the tick edge with empty FIFO is not popped on that tick
    sb(8'h00, 1);
    frame_push("same_tick", 8'h2B, 8'd1);
    chk("same_cnt", fifo_count, 3'd1);
    sb(8'h2B, 1);
    frame("same_next");
    chk("same_cnt2", fifo_count, 3'd0);

    // push and pop on the same edge keeps the count (no gap build pops here)
    push_ev(8'h3C, 8'd1);
    if (GAP_EN) begin
      sb(8'h00, 1);
      frame_push("pp_tick", 8'h4D, 8'd1);
      chk("pp_cnt", fifo_count, 3'd2);
      sb(8'h3C, 1); sb(8'h00, 1); sb(8'h4D, 1); sb(8'h00, 2);
      for (int i = 0; i < 5; i++) frame("pp_seq");
    end else begin
      sb(8'h3C, 1);
      frame_push("pp_tick", 8'h4D, 8'd1);
      chk("pp_cnt", fifo_count, 3'd1);
      sb(8'h4D, 1); sb(8'h00, 1);
      frame("pp_seq"); frame("pp_seq");
    end
    chk("pp_busy", busy, 1'b0);

    // fill to full; fifth push refused
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("full_ready", ev_ready, (i < 4));
      push_ev(8'(i + 1), 8'd1);
    end
    chk("full_cnt", fifo_count, 3'd4);
    // full with a pop: ready stays low, so a held push is not taken
    sb(8'h01, 1);
    frame_push("full_pop", 8'h55, 8'd1);
    chk("full_pop_cnt", fifo_count, 3'd3);
    do_flush();
    @(negedge Clk);
    chk("fl0_key", keycode, 8'h00);
    chk("fl0_cnt", fifo_count, 3'd0);

    // flush mid-hold with two events queued
    push_ev(8'h1A, 8'd10);
    push_ev(8'h21, 8'd1);
    push_ev(8'h22, 8'd1);
    sb(8'h1A, 2);
    frame("fl_t1"); frame("fl_t2");
    chk("fl_pre_cnt", fifo_count, 3'd2);
    do_flush();
    @(negedge Clk);
    chk("fl_key", keycode, 8'h00);
    chk("fl_cnt", fifo_count, 3'd0);
    chk("fl_busy", busy, 1'b0);
    sb(8'h00, 2);
    frame("fl_after"); frame("fl_after");

    // asynchronous reset mid-hold
    push_ev(8'h1A, 8'd10);
    push_ev(8'h22, 8'd2);
    sb(8'h1A, 2);
    frame("ar_t1"); frame("ar_t2");
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("ar_key", keycode, 8'h00);
    chk("ar_busy", busy, 1'b0);
    chk("ar_cnt", fifo_count, 3'd0);
    repeat (3) @(posedge Clk);
    #2 Reset_n = 1'b1;
    sb(8'h00, 2);
    frame("ar_after"); frame("ar_after");
    push_ev(8'h5E, 8'd1);
    sb(8'h5E, 1); sb(8'h00, 2);
    frame("ar_new"); frame("ar_new"); frame("ar_new");
    chk("ar_busy_end", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
